// File: rtl/seq_expr_if.sv
// Handshake and operand/result bundle for seq_expr_unit.
// Master drives the request and operands; slave returns busy, done and the result.
interface seq_expr_if #(
    parameter int unsigned W = 16
);
    logic           start;
    logic [2:0]     mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [W-1:0]   d;
    logic           busy;
    logic           done;
    logic [2*W+1:0] out;

    modport master (output start, mode, a, b, c, d, input busy, done, out);
    modport slave  (input start, mode, a, b, c, d, output busy, done, out);
endinterface

// File: rtl/seq_expr_unit.sv
// Sequential evaluator of R = (A op0 B) * (C op1 D) using a shared add/absdiff stage and a shift-add multiplier.
// Optional SEQ_EXPR_ACCUM_EN: mode[2]=1 accumulates the product into out instead of overwriting it.
module seq_expr_unit #(
    parameter int unsigned W = 16
) (
    input  logic       clk,
    input  logic       rst,
    seq_expr_if.slave  bus
);
    localparam int unsigned SW = W + 1;
    localparam int unsigned RW = 2 * W + 2;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, SUMA, SUMB, MUL, DONE} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [1:0]     mode_q, mode_d;
    logic [SW-1:0]  s0_q, s0_d, s1_q, s1_d;
    logic [RW-1:0]  acc_q, acc_d, out_q, out_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           last_c;
    logic [RW-1:0]  add_c, prod_c;
`ifdef SEQ_EXPR_ACCUM_EN
    logic           accum_q, accum_d;
`else
    logic           unused_mode2;
    assign unused_mode2 = bus.mode[2];
`endif

    // Sum or exact absolute difference, widened so neither can overflow.
    function automatic logic [SW-1:0] op_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sel);
        if (sel) return (x >= y) ? SW'(x - y) : SW'(y - x);
        return SW'(x) + SW'(y);
    endfunction

    assign last_c = (cnt_q == CW'(W));
    assign add_c  = s1_q[cnt_q] ? (RW'(s0_q) << cnt_q) : '0;
    assign prod_c = acc_q + add_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SUMA;
            SUMA:    state_d = SUMB;
            SUMB:    state_d = MUL;
            MUL:     if (last_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        d_d    = d_q;
        mode_d = mode_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        busy_d = busy_q;
        done_d = 1'b0;
`ifdef SEQ_EXPR_ACCUM_EN
        accum_d = accum_q;
`endif
        unique case (state_q)
            IDLE: if (bus.start) begin
                a_d    = bus.a;
                b_d    = bus.b;
                c_d    = bus.c;
                d_d    = bus.d;
                mode_d = bus.mode[1:0];
`ifdef SEQ_EXPR_ACCUM_EN
                accum_d = bus.mode[2];
`endif
                busy_d = 1'b1;
            end
            SUMA: s0_d = op_f(a_q, b_q, mode_q[0]);
            SUMB: begin
                s1_d  = op_f(c_q, d_q, mode_q[1]);
                acc_d = '0;
                cnt_d = '0;
            end
            MUL: begin
                acc_d = prod_c;
                cnt_d = cnt_q + CW'(1);
                if (last_c) begin
`ifdef SEQ_EXPR_ACCUM_EN
                    out_d = accum_q ? (out_q + prod_c) : prod_c;
`else
                    out_d = prod_c;
`endif
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            mode_q <= '0;
            s0_q   <= '0;
            s1_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SEQ_EXPR_ACCUM_EN
            accum_q <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            d_q    <= d_d;
            mode_q <= mode_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef SEQ_EXPR_ACCUM_EN
            accum_q <= accum_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_seq_expr_unit.sv
// Directed self-checking bench for seq_expr_unit (W=16): results, latency, throughput, abort on reset.
module tb_seq_expr_unit;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_expr_if #(.W(W)) bus_if ();
    seq_expr_unit #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] d, input logic [2:0] m, output int t_acc);
        @(negedge clk);
        bus_if.a = a; bus_if.b = b; bus_if.c = c; bus_if.d = d;
        bus_if.mode  = m;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_done(output int t_done, output logic busy_low);
        t_done   = -1;
        busy_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus_if.done) begin
                t_done = cyc;
                break;
            end
            if (!bus_if.busy) busy_low = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d, input logic [2:0] m,
                          input logic [63:0] exp_out);
        int   ta, td;
        logic busy_low;
        launch(a, b, c, d, m, ta);
        chk({tag, "_busy_acc"}, 64'(bus_if.busy), 64'd1);
        wait_done(td, busy_low);
        chk({tag, "_latency"}, 64'(td - ta), 64'(W + 3));
        chk({tag, "_busy_gap"}, 64'(busy_low), 64'd0);
        chk({tag, "_out"}, 64'(bus_if.out), exp_out);
        chk({tag, "_busy_done"}, 64'(bus_if.busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   ta, td, td1, td2;
        logic busy_low, seen;
        logic [63:0] exp6;

        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.mode  = 3'd0;
        bus_if.a = '0; bus_if.b = '0; bus_if.c = '0; bus_if.d = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 64'(bus_if.out), 64'd0);
        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_done", 64'(bus_if.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic sums, absolute differences in both orders, equal operands, widest operands.
        run_op("t1_add", 16'd10, 16'd20, 16'd1, 16'd5, 3'b000, 64'd180);
        run_op("t2_abs", 16'd10, 16'd20, 16'd1, 16'd5, 3'b011, 64'd40);
        run_op("t2_absrev", 16'd20, 16'd10, 16'd5, 16'd1, 3'b011, 64'd40);
        run_op("t2_eq", 16'd7, 16'd7, 16'd1, 16'd5, 3'b001, 64'd0);
        run_op("t3_max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b000, 64'd17179344900);

        // Re-pulse start with new operands mid-MUL: must not disturb the in-flight result.
        launch(16'd3, 16'd4, 16'd5, 16'd6, 3'b000, ta);
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus_if.a = 16'd100; bus_if.b = 16'd200; bus_if.c = 16'd300; bus_if.d = 16'd400;
        bus_if.mode  = 3'b011;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        chk("t4_busy_mid", 64'(bus_if.busy), 64'd1);
        wait_done(td, busy_low);
        chk("t4_latency", 64'(td - ta), 64'(W + 3));
        chk("t4_out", 64'(bus_if.out), 64'd77);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_idle_busy", 64'(bus_if.busy), 64'd0);

        // Start held high: back-to-back completions every W+5 cycles.
        @(negedge clk);
        bus_if.a = 16'd2; bus_if.b = 16'd3; bus_if.c = 16'd4; bus_if.d = 16'd0;
        bus_if.mode  = 3'b000;
        bus_if.start = 1'b1;
        wait_done(td1, busy_low);
        wait_done(td2, busy_low);
        bus_if.start = 1'b0;
        chk("t4_period", 64'(td2 - td1), 64'(W + 5));
        chk("t4_held_out", 64'(bus_if.out), 64'd20);
        @(posedge clk); #1;

        // Asynchronous reset mid-MUL aborts the operation immediately.
        launch(16'd10, 16'd20, 16'd1, 16'd5, 3'b000, ta);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_out", 64'(bus_if.out), 64'd0);
        chk("t5_rst_busy", 64'(bus_if.busy), 64'd0);
        chk("t5_rst_done", 64'(bus_if.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus_if.done || bus_if.busy) seen = 1'b1;
        end
        chk("t5_no_done", 64'(seen), 64'd0);
        run_op("t5_after", 16'd10, 16'd20, 16'd1, 16'd5, 3'b000, 64'd180);

        // Accumulate mode: second result adds onto the first only when the feature is built in.
`ifdef SEQ_EXPR_ACCUM_EN
        exp6 = 64'd220;
`else
        exp6 = 64'd40;
`endif
        run_op("t6_first", 16'd10, 16'd20, 16'd1, 16'd5, 3'b000, 64'd180);
        run_op("t6_accum", 16'd10, 16'd20, 16'd1, 16'd5, 3'b111, exp6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
